i2c_target_rx: RTL and testbench
================================

// Module: i2c_target_rx
// PURPOSE
//   Write-only I2C target (slave) receiver. It is the far end of the mod_I2C master link.
//   - Monitors SCL/SDA, detects START/STOP and matches the 7-bit address.
//   - ACKs by pulling SDA low and delivers each received data byte on a valid/ready strobe.
//   - Sits on the board-side bus next to the master. Its byte output feeds local registers/FIFO.
// PARAMETERS
//   DEV_ADDR     7'h2A  7-bit target address this block answers to
//   SYNC_STAGES  2      synchronizer flops on SCL and SDA inputs (min 2)
// PORTS
//   clk       in     1  system clock, >= 8x SCL frequency
//   rst       in     1  asynchronous, active-low reset
//   SCL       in     1  I2C clock from master (open-drain, externally pulled up)
//   SDA       inout  1  I2C data; block drives only 1'b0 or 1'bz
//   rx_ready  in     1  consumer can accept a byte; sampled at each data-byte ACK point
//   rx_data   out    8  last received data byte, MSB first on the wire
//   rx_valid  out    1  one-clk pulse; rx_data is new this cycle
//   rx_first  out    1  qualifies rx_valid: first data byte after the address
//   busy      out    1  high from address match until STOP/START
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, SDA released (z), rx_data=8'h00,
//     rx_valid=0, rx_first=0, busy=0, bit counter=0.
//   Input conditioning: SCL/SDA pass SYNC_STAGES flops. Edges come from the last two
//     synced samples. All decisions use synced values. Input latency = SYNC_STAGES+1 clk.
//   START: SDA falls while SCL high. Valid in ANY state (repeated start included).
//     -> ADDR, bit count 0, busy=0.
//   STOP: SDA rises while SCL high. Valid in any state.
//     -> IDLE, SDA released, busy=0.
//   Bits are sampled on the synced SCL rising edge and shifted in MSB first.
//   States:
//     IDLE      wait for START
//     ADDR      shift 8 bits (7 addr + R/W). Then:
//                 addr==DEV_ADDR and R/W=0 -> ADDR_ACK
//                 otherwise -> IGNORE (no ACK)
//     ADDR_ACK  drive SDA=0 from the SCL fall after bit 8 to the next SCL fall.
//               busy=1. Then -> DATA, first-byte flag set.
//     DATA      shift 8 bits. On the SCL fall after bit 8, sample rx_ready.
//                 rx_ready=1: rx_data<=byte, rx_valid=1 for 1 clk,
//                   rx_first=first-byte flag, clear flag, -> DATA_ACK (drive SDA=0)
//                 rx_ready=0: byte dropped, rx_valid stays 0, SDA stays z (NACK),
//                   -> IGNORE
//     DATA_ACK  hold SDA=0 until next SCL fall, then release, -> DATA
//     IGNORE    SDA z; only START/STOP leave this state
//   Timing rules:
//     - rx_valid rises the clk after the synced SCL fall that ends bit 8.
//     - rx_data holds until the next accepted byte.
//   SDA is never driven while SCL is high, except during the ACK bit.
//   A STOP/START seen mid-byte discards the partial byte (no rx_valid).
//   START/STOP take priority over a same-cycle SCL edge.
//   Bit counter is 4 bits and wraps 8->0 at each ACK. No other overflow is possible.
//   Reset mid-transfer: SDA released immediately (async), master sees NACK/arb loss.
// TESTING
//   1. START, addr 0x2A+W, bytes 0xA5, 0x3C, STOP, rx_ready=1
//      -> 3 ACKs; rx_valid x2 with rx_data 0xA5 (rx_first=1) then 0x3C (rx_first=0).
//   2. START, addr 0x15+W, 0xFF
//      -> SDA never driven low by target, no rx_valid, busy=0.
//   3. START, addr 0x2A+R
//      -> NACK at bit 9, IGNORE until STOP, no rx_valid.
//   4. Addr ack'd, byte 0x55 with rx_ready=0
//      -> NACK, no rx_valid, rx_data unchanged; next byte 0x66 not received until new START.
//   5. Byte 0x81 half shifted, then repeated START, addr 0x2A+W, 0x81
//      -> one rx_valid, rx_data=0x81, rx_first=1.
//   6. rst=0 asserted while target drives ACK
//      -> SDA=z within same cycle, all outputs reset values; new transaction after release works.

Source files
------------

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: matches DEV_ADDR, ACKs, and delivers each data byte as a one-clk rx_valid pulse.
// Latency: SCL/SDA seen SYNC_STAGES+1 clk late; rx_valid fires the clk after the synced SCL fall ending bit 8.
// Backpressure: rx_ready low at a data-byte ACK point NACKs that byte and ignores the bus until START/STOP.
module i2c_target_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic [3:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   rx_first_q;
    logic                   busy_q;
    logic                   first_q;
    logic                   sda_oe_q;

    logic scl_s;
    logic sda_s;
    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;
    logic byte_done;
    logic addr_match;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign start_det  = scl_s && scl_prev_q && sda_prev_q && !sda_s;
    assign stop_det   = scl_s && scl_prev_q && !sda_prev_q && sda_s;
    assign scl_rise   = scl_s && !scl_prev_q;
    assign scl_fall   = !scl_s && scl_prev_q;
    assign byte_done  = scl_fall && (bit_cnt_q == 4'd8);
    assign addr_match = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];

    // Open-drain: only ever pull low; the oe flop clears asynchronously on reset.
    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign busy     = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            busy_q     <= 1'b0;
            first_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            rx_valid_q <= 1'b0;

            // Bus conditions win over any in-flight byte; a partial byte is simply dropped.
            if (start_det) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= 4'd0;
                busy_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= 4'd0;
                busy_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_DATA: begin
                        if (scl_rise && (bit_cnt_q != 4'd8)) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (byte_done) begin
                            bit_cnt_q <= 4'd0;
                            if (state_q == S_ADDR) begin
                                if (addr_match) begin
                                    state_q  <= S_ADDR_ACK;
                                    sda_oe_q <= 1'b1;
                                    busy_q   <= 1'b1;
                                    first_q  <= 1'b1;
                                end else begin
                                    state_q <= S_IGNORE;
                                end
                            end else if (rx_ready) begin
                                state_q    <= S_DATA_ACK;
                                sda_oe_q   <= 1'b1;
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                                rx_first_q <= first_q;
                                first_q    <= 1'b0;
                            end else begin
                                state_q <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK, S_DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= S_DATA;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench: bit-banged I2C master against i2c_target_rx with hand-computed expectations.
module tb_i2c_target_rx;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       SCL;
    logic       m_low;
    logic       rx_ready;
    wire        SDA;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] ev_d[$];
    logic       ev_f[$];
    int         tlow = 0;

    pullup (SDA);
    assign SDA = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target_rx #(.DEV_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .SCL      (SCL),
        .SDA      (SDA),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .busy     (busy)
    );

    // Record every accepted byte and every moment the target pulls SDA low.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            ev_d.push_back(rx_data);
            ev_f.push_back(rx_first);
        end
        if (!m_low && SDA === 1'b0) tlow++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wq();
        SCL   = 1'b1; wq();
        m_low = 1'b1; wq();
        SCL   = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wq();
        SCL   = 1'b1; wq();
        m_low = 1'b0; wq();
    endtask

    task automatic wbit(input logic b);
        m_low = !b; wq();
        SCL   = 1'b1; wq(); wq();
        SCL   = 1'b0; wq();
    endtask

    task automatic rack(output logic ack);
        m_low = 1'b0; wq();
        SCL   = 1'b1; wq();
        ack   = (SDA === 1'b0);
        wq();
        SCL   = 1'b0; wq();
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rack(ack);
    endtask

    logic ack;
    int   eb;
    int   tb0;

    initial begin
        rst = 1'b0; SCL = 1'b1; m_low = 1'b0; rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst rx_data",  rx_data,  8'h00);
        check("rst rx_valid", rx_valid, 1'b0);
        check("rst rx_first", rx_first, 1'b0);
        check("rst busy",     busy,     1'b0);
        check("rst sda",      SDA,      1'b1);
        rst = 1'b1; wq();

        // 1: two bytes accepted, first-byte flag only on the first
        eb = ev_d.size();
        i2c_start();
        wbyte(8'h54, ack); check("t1 addr ack", ack, 1'b1);
        check("t1 busy", busy, 1'b1);
        wbyte(8'hA5, ack); check("t1 ack A5", ack, 1'b1);
        wbyte(8'h3C, ack); check("t1 ack 3C", ack, 1'b1);
        i2c_stop();
        check("t1 busy after stop", busy, 1'b0);
        check("t1 nbytes", ev_d.size() - eb, 2);
        if (ev_d.size() - eb == 2) begin
            check("t1 d0", ev_d[eb],   8'hA5);
            check("t1 f0", ev_f[eb],   1'b1);
            check("t1 d1", ev_d[eb+1], 8'h3C);
            check("t1 f1", ev_f[eb+1], 1'b0);
        end
        check("t1 rx_data hold", rx_data, 8'h3C);

        // 2: foreign address never driven
        eb = ev_d.size(); tb0 = tlow;
        i2c_start();
        wbyte(8'h2A, ack); check("t2 addr nack", ack, 1'b0);
        wbyte(8'hFF, ack); check("t2 data nack", ack, 1'b0);
        check("t2 busy", busy, 1'b0);
        i2c_stop();
        check("t2 no drive", tlow - tb0, 0);
        check("t2 nbytes", ev_d.size() - eb, 0);

        // 3: own address with read bit
        eb = ev_d.size(); tb0 = tlow;
        i2c_start();
        wbyte(8'h55, ack); check("t3 addr nack", ack, 1'b0);
        wbyte(8'h00, ack); check("t3 data nack", ack, 1'b0);
        check("t3 busy", busy, 1'b0);
        i2c_stop();
        check("t3 no drive", tlow - tb0, 0);
        check("t3 nbytes", ev_d.size() - eb, 0);

        // 4: consumer not ready -> NACK and ignore rest of transfer
        eb = ev_d.size();
        i2c_start();
        wbyte(8'h54, ack); check("t4 addr ack", ack, 1'b1);
        rx_ready = 1'b0;
        wbyte(8'h55, ack); check("t4 nack 55", ack, 1'b0);
        check("t4 rx_data kept", rx_data, 8'h3C);
        rx_ready = 1'b1;
        wbyte(8'h66, ack); check("t4 nack 66", ack, 1'b0);
        check("t4 busy held", busy, 1'b1);
        i2c_stop();
        check("t4 busy after stop", busy, 1'b0);
        check("t4 nbytes", ev_d.size() - eb, 0);

        // 5: repeated start mid-byte discards the partial byte
        eb = ev_d.size();
        i2c_start();
        wbyte(8'h54, ack); check("t5 addr ack", ack, 1'b1);
        wbit(1'b1); wbit(1'b0); wbit(1'b0); wbit(1'b0);
        i2c_start();
        check("t5 busy after rstart", busy, 1'b0);
        wbyte(8'h54, ack); check("t5 addr2 ack", ack, 1'b1);
        wbyte(8'h81, ack); check("t5 ack 81", ack, 1'b1);
        i2c_stop();
        check("t5 nbytes", ev_d.size() - eb, 1);
        if (ev_d.size() - eb == 1) begin
            check("t5 d0", ev_d[eb], 8'h81);
            check("t5 f0", ev_f[eb], 1'b1);
        end

        // 6: reset while target holds the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(1'(8'h54 >> i));
        m_low = 1'b0; wq();
        SCL = 1'b1; wq();
        check("t6 ack driven", SDA, 1'b0);
        rst = 1'b0;
        #1;
        check("t6 sda released", SDA,      1'b1);
        check("t6 rx_data",      rx_data,  8'h00);
        check("t6 rx_valid",     rx_valid, 1'b0);
        check("t6 rx_first",     rx_first, 1'b0);
        check("t6 busy",         busy,     1'b0);
        @(negedge clk);
        SCL = 1'b0; wq();
        rst = 1'b1; wq();
        i2c_stop();
        eb = ev_d.size();
        i2c_start();
        wbyte(8'h54, ack); check("t6 new addr ack", ack, 1'b1);
        wbyte(8'h12, ack); check("t6 new ack 12", ack, 1'b1);
        i2c_stop();
        check("t6 nbytes", ev_d.size() - eb, 1);
        if (ev_d.size() - eb == 1) begin
            check("t6 d0", ev_d[eb], 8'h12);
            check("t6 f0", ev_f[eb], 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
